// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU types for register-file write-back: address/data widths,
// the per-source write request and the arbiter grant identity.
package cpu_pkg;

    localparam int REG_AW = 4;
    localparam int REG_DW = 16;
    localparam int NREG   = 16;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back handshake bundle for the two register-file write sources.
// The master side is the execute/memory stage pair, the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 16
);

    logic          s0_valid;
    logic          s0_ready;
    logic [AW-1:0] s0_addr;
    logic [DW-1:0] s0_data;

    logic          s1_valid;
    logic          s1_ready;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_data;

    modport master (
        output s0_valid, s0_addr, s0_data,
        input  s0_ready,
        output s1_valid, s1_addr, s1_data,
        input  s1_ready
    );

    modport slave (
        input  s0_valid, s0_addr, s0_data,
        output s0_ready,
        input  s1_valid, s1_addr, s1_data,
        output s1_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue,
// cleared when the write-back is accepted, wiped by a pipeline flush.
module wb_scoreboard #(
    parameter int AW   = 4,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_valid,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_valid,
    input  logic [AW-1:0]   clr_addr,
    input  logic            flush,
    input  logic [AW-1:0]   chk_a1,
    input  logic [AW-1:0]   chk_a2,
    output logic            hz1,
    output logic            hz2,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Ordering gives flush > set > clear when they hit the same register.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) busy_d[clr_addr] = 1'b0;
        if (set_valid) busy_d[set_addr] = 1'b1;
        if (flush)     busy_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign hz1  = busy_q[chk_a1];
    assign hz2  = busy_q[chk_a2];
    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// execute and load write-back sources, with a registered port drive.
module regfile_wb_arbiter
    import cpu_pkg::wb_req_t;
    import cpu_pkg::src_t;
    import cpu_pkg::SRC0;
    import cpu_pkg::SRC1;
#(
    parameter int DW   = 16,
    parameter int AW   = 4,
    parameter int NREG = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_arbiter_if.slave wb,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_dst,
    input  logic               flush,
    input  logic [AW-1:0]      chk_a1,
    input  logic [AW-1:0]      chk_a2,
    output logic               hz1,
    output logic               hz2,
    output logic               rf_wre,
    output logic [AW-1:0]      rf_a3,
    output logic [DW-1:0]      rf_wd3,
    output logic [NREG-1:0]    busy
);

    wb_req_t req0;
    wb_req_t req1;
    src_t    last_grant;
    logic    grant0;
    logic    grant1;

    always_comb begin
        req0.valid = wb.s0_valid;
        req0.addr  = wb.s0_addr;
        req0.data  = wb.s0_data;
        req1.valid = wb.s1_valid;
        req1.addr  = wb.s1_addr;
        req1.data  = wb.s1_data;
    end

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0.valid && (!req1.valid || last_grant == SRC1)) grant0 = 1'b1;
            else if (req1.valid)                                   grant1 = 1'b1;
        end
    end

    assign wb.s0_ready = grant0;
    assign wb.s1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC1;
            rf_wre     <= 1'b0;
            rf_a3      <= '0;
            rf_wd3     <= '0;
        end else begin
            rf_wre <= grant0 | grant1;
            if (grant0) begin
                last_grant <= SRC0;
                rf_a3      <= req0.addr;
                rf_wd3     <= req0.data;
            end else if (grant1) begin
                last_grant <= SRC1;
                rf_a3      <= req1.addr;
                rf_wd3     <= req1.data;
            end
        end
    end

    wb_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (iss_valid),
        .set_addr  (iss_dst),
        .clr_valid (grant0 | grant1),
        .clr_addr  (grant0 ? req0.addr : req1.addr),
        .flush     (flush),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hz1       (hz1),
        .hz2       (hz2),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus pushes expected port writes
// into a queue, a negedge monitor pops and compares them against the write port.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_dst;
    logic        flush;
    logic [3:0]  chk_a1;
    logic [3:0]  chk_a2;
    logic        hz1;
    logic        hz2;
    logic        rf_wre;
    logic [3:0]  rf_a3;
    logic [15:0] rf_wd3;
    logic [15:0] busy;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.AW(4), .DW(16)) wb ();

    regfile_wb_arbiter #(
        .DW   (16),
        .AW   (4),
        .NREG (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb        (wb),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .flush     (flush),
        .chk_a1    (chk_a1),
        .chk_a2    (chk_a2),
        .hz1       (hz1),
        .hz2       (hz2),
        .rf_wre    (rf_wre),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A source that is not accepted must keep its request stable.
    a_s0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wb.s0_valid && !wb.s0_ready) |=> (wb.s0_valid && $stable(wb.s0_addr) && $stable(wb.s0_data)))
        else begin n_fail++; $display("FAIL s0_protocol_hold at cycle %0d", cyc); end
    a_s1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wb.s1_valid && !wb.s1_ready) |=> (wb.s1_valid && $stable(wb.s1_addr) && $stable(wb.s1_data)))
        else begin n_fail++; $display("FAIL s1_protocol_hold at cycle %0d", cyc); end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every port write must match the queue head in cycle, address and data.
    always @(negedge clk) begin
        if (rf_wre === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write at cycle %0d: a3=%0d wd3=0x%0h, expected no write",
                         cyc, rf_a3, rf_wd3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || rf_a3 !== e.a || rf_wd3 !== e.d) begin
                    n_fail++;
                    $display("FAIL port_write: got cycle %0d a3=%0d wd3=0x%0h, expected cycle %0d a3=%0d wd3=0x%0h",
                             cyc, rf_a3, rf_wd3, e.cyc, e.a, e.d);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_write at cycle %0d: got rf_wre=%b, expected a3=%0d wd3=0x%0h",
                     cyc, rf_wre, e.a, e.d);
        end
    end

    // Drive one cycle of inputs, check the combinational/current-state outputs,
    // record the expected write, then advance to just after the next edge.
    task automatic vec(input logic s0v, input logic [3:0] s0a, input logic [15:0] s0d,
                       input logic s1v, input logic [3:0] s1a, input logic [15:0] s1d,
                       input logic iv, input logic [3:0] id, input logic fl,
                       input logic [3:0] c1, input logic [3:0] c2,
                       input logic er0, input logic er1,
                       input logic [15:0] ebusy, input logic eh1, input logic eh2);
        wb.s0_valid = s0v; wb.s0_addr = s0a; wb.s0_data = s0d;
        wb.s1_valid = s1v; wb.s1_addr = s1a; wb.s1_data = s1d;
        iss_valid = iv; iss_dst = id; flush = fl;
        chk_a1 = c1; chk_a2 = c2;
        #1;
        chk("s0_ready", {31'd0, wb.s0_ready}, {31'd0, er0});
        chk("s1_ready", {31'd0, wb.s1_ready}, {31'd0, er1});
        chk("busy", {16'd0, busy}, {16'd0, ebusy});
        chk("hz1", {31'd0, hz1}, {31'd0, eh1});
        chk("hz2", {31'd0, hz2}, {31'd0, eh2});
        if (er0) exp_q.push_back('{cyc: cyc + 1, a: s0a, d: s0d});
        if (er1) exp_q.push_back('{cyc: cyc + 1, a: s1a, d: s1d});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wb.s0_valid = 1'b1; wb.s0_addr = 4'd1; wb.s0_data = 16'h1111;
        wb.s1_valid = 1'b1; wb.s1_addr = 4'd2; wb.s1_data = 16'h2222;
        iss_valid = 1'b0; iss_dst = '0; flush = 1'b0; chk_a1 = '0; chk_a2 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_s0_ready", {31'd0, wb.s0_ready}, 32'd0);
        chk("rst_s1_ready", {31'd0, wb.s1_ready}, 32'd0);
        chk("rst_rf_wre", {31'd0, rf_wre}, 32'd0);
        chk("rst_rf_a3", {28'd0, rf_a3}, 32'd0);
        chk("rst_rf_wd3", {16'd0, rf_wd3}, 32'd0);
        chk("rst_busy", {16'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Conflict after reset: src0 first, then strict alternation.
        vec(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0, 0, 4'd0, 4'd0, 1, 0, 16'h0000, 0, 0);
        vec(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1, 16'h0000, 0, 0);
        vec(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0, 0, 4'd0, 4'd0, 1, 0, 16'h0000, 0, 0);
        vec(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1, 16'h0000, 0, 0);
        vec(1, 4'd1, 16'h1111, 0, 4'd2, 16'h2222, 0, 4'd0, 0, 4'd0, 4'd0, 1, 0, 16'h0000, 0, 0);
        // Single source write r3, then idle
        vec(1, 4'd3, 16'h00AB, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 4'd0, 1, 0, 16'h0000, 0, 0);
        vec(0, 4'd3, 16'h00AB, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'h0000, 0, 0);
        // Scoreboard basic on r5
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd5, 0, 4'd5, 4'd0, 0, 0, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 1, 4'd5, 16'h5555, 0, 4'd0, 0, 4'd5, 4'd0, 0, 1, 16'h0020, 1, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd5, 4'd0, 0, 0, 16'h0000, 0, 0);
        // Set/clear collision on r7: set wins; then flush overrides both
        vec(1, 4'd7, 16'h7777, 0, 4'd0, 16'h0000, 1, 4'd7, 0, 4'd7, 4'd5, 1, 0, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd7, 4'd7, 0, 0, 16'h0080, 1, 1);
        vec(1, 4'd7, 16'h7070, 0, 4'd0, 16'h0000, 1, 4'd7, 1, 4'd7, 4'd0, 1, 0, 16'h0080, 1, 0);
        // Set and clear on different registers, transfer to idle r0, r0/r15 bits
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd4, 0, 4'd4, 4'd4, 0, 0, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 1, 4'd4, 16'h4444, 1, 4'd9, 0, 4'd4, 4'd9, 0, 1, 16'h0010, 1, 0);
        vec(1, 4'd0, 16'h0F0F, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd9, 4'd0, 1, 0, 16'h0200, 1, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd0, 0, 4'd0, 4'd15, 0, 0, 16'h0200, 0, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd15, 0, 4'd0, 4'd15, 0, 0, 16'h0201, 1, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd15, 4'd9, 0, 0, 16'h8201, 1, 1);
        // Conflict with src0 as last winner: src1 goes first
        vec(1, 4'd6, 16'h6666, 1, 4'd8, 16'h8888, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1, 16'h8201, 1, 1);
        vec(1, 4'd6, 16'h6666, 1, 4'd8, 16'h8888, 0, 4'd0, 0, 4'd0, 4'd0, 1, 0, 16'h8201, 1, 1);
        vec(0, 4'd0, 16'h0000, 1, 4'd8, 16'h8888, 0, 4'd0, 0, 4'd0, 4'd0, 0, 1, 16'h8201, 1, 1);
        // Back-to-back stream, then asynchronous reset between edges
        vec(1, 4'd10, 16'hAAAA, 1, 4'd11, 16'hBBBB, 1, 4'd12, 0, 4'd12, 4'd15, 1, 0, 16'h8201, 0, 1);
        iss_valid = 1'b0;
        chk("pre_rst_busy", {16'd0, busy}, 32'h0000_9201);
        chk("pre_rst_rf_wre", {31'd0, rf_wre}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rf_wre", {31'd0, rf_wre}, 32'd0);
        chk("async_rf_a3", {28'd0, rf_a3}, 32'd0);
        chk("async_rf_wd3", {16'd0, rf_wd3}, 32'd0);
        chk("async_busy", {16'd0, busy}, 32'd0);
        chk("async_s0_ready", {31'd0, wb.s0_ready}, 32'd0);
        chk("async_s1_ready", {31'd0, wb.s1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // After release src0 regains priority even though it won last before reset.
        vec(1, 4'd10, 16'hAAAA, 1, 4'd11, 16'hBBBB, 0, 4'd0, 0, 4'd12, 4'd15, 1, 0, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 1, 4'd11, 16'hBBBB, 0, 4'd0, 0, 4'd12, 4'd15, 0, 1, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'h0000, 0, 0);
        vec(0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 0, 4'd0, 4'd0, 0, 0, 16'h0000, 0, 0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
